// File: rtl/pio_input_pkg.sv
// Shared constants and helpers for the edge-capturing PIO input port.
package pio_input_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before the flip.
    function automatic int deb_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pio_bit_debounce.sv
// Single-bit debouncer: conditioned bit follows the synchronised bit only after
// DEBOUNCE_CYCLES consecutive differing clocks; bypassed while arm is high.
module pio_bit_debounce
    import pio_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arm,
    input  logic sync_in,
    output logic cond_out
);

    localparam int CW = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_reg;
    logic          cond_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg  <= '0;
            cond_reg <= 1'b0;
        end else if (arm) begin
            cnt_reg  <= '0;
            cond_reg <= sync_in;
        end else if (sync_in != cond_reg) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_reg  <= '0;
                cond_reg <= sync_in;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    // During the arm window the raw synchronised bit is passed straight through
    // so the edge detector's delayed copy tracks it without a spurious edge.
    assign cond_out = arm ? sync_in : cond_reg;

endmodule

// File: rtl/pio_input_edgecap.sv
// N-bit Avalon-MM input port with synchroniser, edge capture (W1C) and masked IRQ.
// Optional per-bit debouncing is built when PIO_INPUT_DEBOUNCE_EN is defined.
module pio_input_edgecap
    import pio_input_pkg::*;
#(
    parameter int DATA_WIDTH      = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    localparam int ARM_LOAD = SYNC_STAGES + 1;
    localparam int ARM_W    = $clog2(SYNC_STAGES + 2);

    logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_out;
    logic [DATA_WIDTH-1:0] cond_val;
    logic [DATA_WIDTH-1:0] prev_reg;
    logic [DATA_WIDTH-1:0] edge_raw;
    logic [DATA_WIDTH-1:0] edge_hit;
    logic [DATA_WIDTH-1:0] irqmask_reg;
    logic [DATA_WIDTH-1:0] edgecap_reg;
    logic [DATA_WIDTH-1:0] w1c_mask;
    logic [ARM_W-1:0]      arm_cnt_reg;
    logic                  arm;
    logic                  wr_en;
    logic [31:0]           rd_word;
    logic [31:0]           readdata_reg;
    logic                  unused_wdata;

    genvar gi;

    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!reset_n) sync_reg[gi] <= '0;
                    else          sync_reg[gi] <= in_port;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (!reset_n) sync_reg[gi] <= '0;
                    else          sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n)                 arm_cnt_reg <= ARM_W'(ARM_LOAD);
        else if (arm_cnt_reg != '0)   arm_cnt_reg <= arm_cnt_reg - ARM_W'(1);
    end

    assign arm = (arm_cnt_reg != '0);

`ifdef PIO_INPUT_DEBOUNCE_EN
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_deb
            pio_bit_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .arm     (arm),
                .sync_in (sync_out[gi]),
                .cond_out(cond_val[gi])
            );
        end
    endgenerate
`else
    assign cond_val = sync_out;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) prev_reg <= '0;
        else          prev_reg <= cond_val;
    end

    always_comb begin
        if (EDGE_TYPE == EDGE_FALL)     edge_raw = ~cond_val & prev_reg;
        else if (EDGE_TYPE == EDGE_ANY) edge_raw = cond_val ^ prev_reg;
        else                            edge_raw = cond_val & ~prev_reg;
    end

    assign edge_hit = arm ? '0 : edge_raw;
    assign wr_en    = chipselect && write;
    assign w1c_mask = (wr_en && address == ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_reg <= '0;
            edgecap_reg <= '0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) irqmask_reg <= writedata[DATA_WIDTH-1:0];
            // A new edge in the same cycle as its clear keeps the bit set.
            edgecap_reg <= (edgecap_reg & ~w1c_mask) | edge_hit;
        end
    end

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA:    rd_word[DATA_WIDTH-1:0] = cond_val;
            ADDR_DIR:     rd_word = '0;
            ADDR_IRQMASK: rd_word[DATA_WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: rd_word[DATA_WIDTH-1:0] = edgecap_reg;
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) readdata_reg <= '0;
        else          readdata_reg <= rd_word;
    end

    assign readdata     = readdata_reg;
    assign irq          = |(edgecap_reg & irqmask_reg);
    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_input_edgecap.sv
// Directed bench for pio_input_edgecap: rising-edge and any-edge instances share one bus.
module tb_pio_input_edgecap;

`ifdef PIO_INPUT_DEBOUNCE_EN
    localparam int LAT = 2 + 8 + 1;
`else
    localparam int LAT = 2 + 1;
`endif
    localparam int SETTLE = LAT + 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_rise, rd_any;
    logic        irq_rise, irq_any;
    logic [31:0] r0, r1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pio_input_edgecap #(
        .DATA_WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)
    ) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(rd_rise),
        .in_port(in_port), .irq(irq_rise)
    );

    pio_input_edgecap #(
        .DATA_WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .irq(irq_any)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = data;
        tick(1);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        $display("write addr=%0d data=0x%08h irq_rise=%0b", addr, data, irq_rise);
    endtask

    task automatic read_both(input logic [1:0] addr, output logic [31:0] d0, output logic [31:0] d1);
        address = addr;
        tick(1);
        d0 = rd_rise;
        d1 = rd_any;
        $display("read  addr=%0d rise=0x%08h any=0x%08h", addr, d0, d1);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        in_port    = 4'hA;
        tick(2);
        check("rst_readdata", rd_rise, 32'h0);
        check("rst_irq", {31'b0, irq_rise}, 32'h0);

        // 1: input held high through reset -> value visible, nothing captured
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t1_irq_quiet", {31'b0, irq_rise}, 32'h0);
        end
        check("t1_data", rd_rise, 32'h0000_000A);
        read_both(2'd3, r0, r1);
        check("t1_edgecap_rise", r0, 32'h0);
        check("t1_edgecap_any", r1, 32'h0);
        read_both(2'd1, r0, r1);
        check("t1_dir", r0, 32'h0);

        in_port = 4'h0;
        tick(SETTLE);
        bus_write(2'd3, 32'hF);

        // 2: masked bit0 rising edge raises irq after LAT edges, W1C drops it
        bus_write(2'd2, 32'h1);
        in_port = 4'h1;
        tick(LAT - 1);
        check("t2_irq_early", {31'b0, irq_rise}, 32'h0);
        tick(1);
        check("t2_irq_set", {31'b0, irq_rise}, 32'h1);
        read_both(2'd3, r0, r1);
        check("t2_edgecap", r0, 32'h1);
        read_both(2'd2, r0, r1);
        check("t2_irqmask", r0, 32'h1);
        bus_write(2'd3, 32'h1);
        check("t2_irq_clr", {31'b0, irq_rise}, 32'h0);
        read_both(2'd3, r0, r1);
        check("t2_edgecap_clr", r0, 32'h0);

        // 3: unmasked bit2 edge captured silently, then unmasked
        in_port = 4'h5;
        tick(SETTLE);
        check("t3_irq_masked", {31'b0, irq_rise}, 32'h0);
        read_both(2'd3, r0, r1);
        check("t3_edgecap", r0, 32'h4);
        bus_write(2'd2, 32'h4);
        check("t3_irq_unmask", {31'b0, irq_rise}, 32'h1);

        // 4: clear of bit0 colliding with a new bit0 edge keeps the bit
        bus_write(2'd2, 32'h5);
        in_port = 4'h4;
        tick(SETTLE);
        in_port = 4'h5;
        tick(SETTLE);
        read_both(2'd3, r0, r1);
        check("t4_edgecap_pre", r0, 32'h5);
        in_port = 4'h4;
        tick(SETTLE);
        in_port = 4'h5;
        tick(LAT - 1);
        bus_write(2'd3, 32'h1);
        check("t4_irq_hold", {31'b0, irq_rise}, 32'h1);
        read_both(2'd3, r0, r1);
        check("t4_set_wins", r0, 32'h5);
        bus_write(2'd3, 32'h1);
        read_both(2'd3, r0, r1);
        check("t4_clear_alone", r0, 32'h4);

        // 5: bit3 falling edge seen by the any-edge instance only
        bus_write(2'd3, 32'hF);
        in_port = 4'hC;
        tick(SETTLE);
        bus_write(2'd3, 32'hF);
        read_both(2'd3, r0, r1);
        check("t5_pre_any", r1, 32'h0);
        in_port = 4'h4;
        tick(SETTLE);
        read_both(2'd3, r0, r1);
        check("t5_fall_any", r1, 32'h8);
        check("t5_fall_rise", r0, 32'h0);

`ifdef PIO_INPUT_DEBOUNCE_EN
        // 6: short pulse filtered, long pulse accepted after the window
        bus_write(2'd3, 32'hF);
        address = 2'd0;
        in_port = 4'h6;
        tick(5);
        in_port = 4'h4;
        tick(20);
        check("t6_short_data", rd_rise, 32'h4);
        read_both(2'd3, r0, r1);
        check("t6_short_edgecap", r0, 32'h0);
        address = 2'd0;
        in_port = 4'h6;
        tick(LAT - 1);
        check("t6_long_data_early", rd_rise, 32'h4);
        tick(1);
        check("t6_long_data", rd_rise, 32'h6);
        tick(9);
        in_port = 4'h4;
        read_both(2'd3, r0, r1);
        check("t6_long_edgecap", r0, 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
